// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoded ID-slot fields, EX/MEM feedback for forwarding,
// and the registered EX-side outputs of the pipeline register.
interface id_ex_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int OP_W   = 13,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              stall_in;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic [3:0]        id_shamt;
  logic [OP_W-1:0]   id_alu_op;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [DATA_W-1:0] ex_result;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;

  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;
  logic [3:0]        ex_shamt;
  logic [OP_W-1:0]   ex_alu_op;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_valid;
  logic              id_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output flush, stall_in, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rdata1, id_rdata2, id_imm, id_use_imm, id_shamt, id_alu_op,
           id_reg_write, id_mem_read, ex_result, mem_reg_write, mem_rd, mem_data,
    input  ex_op1, ex_op2, ex_shamt, ex_alu_op, ex_rd, ex_reg_write, ex_mem_read,
           ex_valid, id_stall, bubble_cnt
  );

  modport slave (
    input  flush, stall_in, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rdata1, id_rdata2, id_imm, id_use_imm, id_shamt, id_alu_op,
           id_reg_write, id_mem_read, ex_result, mem_reg_write, mem_rd, mem_data,
    output ex_op1, ex_op2, ex_shamt, ex_alu_op, ex_rd, ex_reg_write, ex_mem_read,
           ex_valid, id_stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard detection and bubble insertion.
// Define FWD_EN to add EX/MEM operand forwarding (only load-use then bubbles).
module id_ex_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int OP_W    = 13,
  parameter int NOP_BIT = 10,
  parameter int CNT_W   = 16
) (
  input logic    clk,
  input logic    rst,
  id_ex_if.slave bus
);

  localparam logic [OP_W-1:0] NOP_OP = OP_W'(1) << NOP_BIT;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [3:0]        shamt;
    logic [OP_W-1:0]   alu_op;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              valid;
  } ex_t;

  localparam ex_t BUBBLE = '{op1: '0, op2: '0, shamt: '0, alu_op: NOP_OP,
                             rd: '0, reg_write: 1'b0, mem_read: 1'b0, valid: 1'b0};

  ex_t              r_ex;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic             w_m1_ex, w_m1_mem, w_m2_ex, w_m2_mem;
  logic             w_hazard;
  ex_t              w_load;

  // The instruction now in EX is whatever this register holds, so its
  // destination and write-enable are the EX-side match sources.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_load           = BUBBLE;
    w_m1_ex  = bus.id_valid & bus.id_rs1_used & (bus.id_rs1 == r_ex.rd)   & r_ex.reg_write;
    w_m2_ex  = bus.id_valid & bus.id_rs2_used & (bus.id_rs2 == r_ex.rd)   & r_ex.reg_write;
    w_m1_mem = bus.id_valid & bus.id_rs1_used & (bus.id_rs1 == bus.mem_rd) & bus.mem_reg_write;
    w_m2_mem = bus.id_valid & bus.id_rs2_used & (bus.id_rs2 == bus.mem_rd) & bus.mem_reg_write;

    w_load.shamt     = bus.id_shamt;
    w_load.alu_op    = bus.id_alu_op;
    w_load.rd        = bus.id_rd;
    w_load.reg_write = bus.id_reg_write;
    w_load.mem_read  = bus.id_mem_read;
    w_load.valid     = 1'b1;
`ifdef FWD_EN
    // Load data is not ready until MEM, so only an EX match on a load bubbles.
    w_hazard   = (w_m1_ex | w_m2_ex) & r_ex.mem_read;
    w_load.op1 = w_m1_ex  ? bus.ex_result :
                 w_m1_mem ? bus.mem_data  : bus.id_rdata1;
    w_load.op2 = bus.id_use_imm ? bus.id_imm    :
                 w_m2_ex        ? bus.ex_result :
                 w_m2_mem       ? bus.mem_data  : bus.id_rdata2;
`else
    w_hazard   = w_m1_ex | w_m2_ex | w_m1_mem | w_m2_mem;
    w_load.op1 = bus.id_rdata1;
    w_load.op2 = bus.id_use_imm ? bus.id_imm : bus.id_rdata2;
`endif
  end

  assign bus.id_stall = bus.stall_in | (w_hazard & ~bus.flush);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex         <= BUBBLE;
      r_bubble_cnt <= '0;
    end else if (bus.flush) begin
      r_ex <= BUBBLE;
    end else if (!bus.stall_in) begin
      if (w_hazard || !bus.id_valid) begin
        r_ex <= BUBBLE;
        if (w_hazard && (r_bubble_cnt != '1))
          r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end else begin
        r_ex <= w_load;
      end
    end
  end

  assign bus.ex_op1       = r_ex.op1;
  assign bus.ex_op2       = r_ex.op2;
  assign bus.ex_shamt     = r_ex.shamt;
  assign bus.ex_alu_op    = r_ex.alu_op;
  assign bus.ex_rd        = r_ex.rd;
  assign bus.ex_reg_write = r_ex.reg_write;
  assign bus.ex_mem_read  = r_ex.mem_read;
  assign bus.ex_valid     = r_ex.valid;
  assign bus.bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a rule-level reference model predicts each
// edge, a separate monitor pops and compares the registered outputs.
module tb_id_ex_stage;

  localparam logic [12:0] NOP = 13'h0400;

  typedef struct {
    logic [15:0] op1, op2;
    logic [3:0]  shamt;
    logic [12:0] alu;
    logic [2:0]  rd;
    logic        rw, mr, v;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  id_ex_if bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t bub(logic [15:0] c);
    exp_t b;
    b = '{op1: 16'h0, op2: 16'h0, shamt: 4'h0, alu: NOP, rd: 3'h0,
          rw: 1'b0, mr: 1'b0, v: 1'b0, cnt: c};
    return b;
  endfunction

  task automatic idle();
    bus.flush = 0; bus.stall_in = 0; bus.id_valid = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_used = 0; bus.id_rs2_used = 0;
    bus.id_rd = 0; bus.id_rdata1 = 0; bus.id_rdata2 = 0; bus.id_imm = 0;
    bus.id_use_imm = 0; bus.id_shamt = 0; bus.id_alu_op = 13'h0001;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.ex_result = 0;
    bus.mem_reg_write = 0; bus.mem_rd = 0; bus.mem_data = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  // Reference model: apply the stage rules to the current inputs and the
  // predicted EX contents, check id_stall, queue the post-edge expectation.
  task automatic step();
    exp_t n;
    bit   e1, e2, w1, w2, haz;
    #1;
    e1 = bus.id_valid && bus.id_rs1_used && bus.id_rs1 == m.rd && m.rw;
    e2 = bus.id_valid && bus.id_rs2_used && bus.id_rs2 == m.rd && m.rw;
    w1 = bus.id_valid && bus.id_rs1_used && bus.id_rs1 == bus.mem_rd && bus.mem_reg_write;
    w2 = bus.id_valid && bus.id_rs2_used && bus.id_rs2 == bus.mem_rd && bus.mem_reg_write;
`ifdef FWD_EN
    haz = (e1 || e2) && m.mr;
`else
    haz = e1 || e2 || w1 || w2;
`endif
    check("id_stall", bus.id_stall, bus.stall_in || (haz && !bus.flush));
    n = m;
    if (bus.flush) n = bub(m.cnt);
    else if (bus.stall_in) n = m;
    else if (haz || !bus.id_valid) begin
      n = bub(m.cnt);
      if (haz && m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
    end else begin
`ifdef FWD_EN
      n.op1 = e1 ? bus.ex_result : w1 ? bus.mem_data : bus.id_rdata1;
      n.op2 = bus.id_use_imm ? bus.id_imm : e2 ? bus.ex_result : w2 ? bus.mem_data : bus.id_rdata2;
`else
      n.op1 = bus.id_rdata1;
      n.op2 = bus.id_use_imm ? bus.id_imm : bus.id_rdata2;
`endif
      n.shamt = bus.id_shamt; n.alu = bus.id_alu_op; n.rd = bus.id_rd;
      n.rw = bus.id_reg_write; n.mr = bus.id_mem_read; n.v = 1'b1;
    end
    m = n;
    sb.push_back(n);
  endtask

  // Monitor: the outputs after each edge must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ex_op1", bus.ex_op1, e.op1);
        check("ex_op2", bus.ex_op2, e.op2);
        check("ex_shamt", bus.ex_shamt, e.shamt);
        check("ex_alu_op", bus.ex_alu_op, e.alu);
        check("ex_rd", bus.ex_rd, e.rd);
        check("ex_reg_write", bus.ex_reg_write, e.rw);
        check("ex_mem_read", bus.ex_mem_read, e.mr);
        check("ex_valid", bus.ex_valid, e.v);
        check("bubble_cnt", bus.bubble_cnt, e.cnt);
      end
    end
  end

  // Async reset without a clock edge; id_stall keeps tracking its inputs.
  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1;
    #1;
    check("rst_alu_op", bus.ex_alu_op, NOP);
    check("rst_valid", bus.ex_valid, 1'b0);
    check("rst_op1", bus.ex_op1, 16'h0);
    check("rst_bubble_cnt", bus.bubble_cnt, 16'h0);
    idle();
    bus.stall_in = 1;
    #1 check("rst_id_stall_hi", bus.id_stall, 1'b1);
    bus.stall_in = 0;
    #1 check("rst_id_stall_lo", bus.id_stall, 1'b0);
    m = bub(16'h0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic rand_cycle();
    nxt();
    bus.flush = ($urandom_range(0, 9) == 0);
    bus.stall_in = ($urandom_range(0, 5) == 0);
    bus.id_valid = ($urandom_range(0, 4) != 0);
    bus.id_rs1 = 3'($urandom_range(0, 3));
    bus.id_rs2 = 3'($urandom_range(0, 3));
    bus.id_rs1_used = 1'($urandom);
    bus.id_rs2_used = 1'($urandom);
    bus.id_rd = 3'($urandom_range(0, 3));
    bus.id_rdata1 = 16'($urandom);
    bus.id_rdata2 = 16'($urandom);
    bus.id_imm = 16'($urandom);
    bus.id_use_imm = 1'($urandom);
    bus.id_shamt = 4'($urandom);
    bus.id_alu_op = 13'(1) << $urandom_range(0, 12);
    bus.id_reg_write = 1'($urandom);
    bus.id_mem_read = ($urandom_range(0, 2) == 0);
    bus.ex_result = 16'($urandom);
    bus.mem_reg_write = 1'($urandom);
    bus.mem_rd = 3'($urandom_range(0, 3));
    bus.mem_data = 16'($urandom);
    step();
  endtask

  task automatic sub_r1(logic [15:0] d1);
    bus.id_valid = 1; bus.id_rs1 = 1; bus.id_rs2 = 3;
    bus.id_rs1_used = 1; bus.id_rs2_used = 1; bus.id_rd = 2;
    bus.id_reg_write = 1; bus.id_rdata1 = d1; bus.id_rdata2 = 16'h0002;
    bus.id_alu_op = 13'h0002;
  endtask

  task automatic use_r4(logic [15:0] d1);
    bus.id_valid = 1; bus.id_rs1 = 4; bus.id_rs1_used = 1;
    bus.id_rd = 5; bus.id_reg_write = 1; bus.id_rdata1 = d1;
  endtask

  initial begin
    rst = 1;
    idle();
    m = bub(16'h0);
    repeat (2) @(negedge clk);
    rst = 0;

    repeat (400) rand_cycle();
    do_reset();

    // EX holds ADD r1 (result 0x0005); ID issues SUB r2 = r1 - r3.
    nxt(); bus.id_valid = 1; bus.id_rd = 1; bus.id_reg_write = 1; step();
    nxt(); sub_r1(16'h0000); bus.ex_result = 16'h0005; step();
`ifndef FWD_EN
    check("t2_stall_ex", bus.id_stall, 1'b1);
    nxt(); sub_r1(16'h0000); bus.mem_reg_write = 1; bus.mem_rd = 1; bus.mem_data = 16'h0005; step();
    check("t2_stall_mem", bus.id_stall, 1'b1);
    nxt(); sub_r1(16'h0005); step();
    check("t2_stall_clear", bus.id_stall, 1'b0);
`endif
    @(posedge clk); #2;
    check("t2_op1", bus.ex_op1, 16'h0005);
    check("t2_op2", bus.ex_op2, 16'h0002);

    // Load-use on r4, then MEM delivers 0xBEEF.
    do_reset();
    nxt(); bus.id_valid = 1; bus.id_rd = 4; bus.id_reg_write = 1; bus.id_mem_read = 1; step();
    nxt(); use_r4(16'h0000); step();
    check("t3_stall", bus.id_stall, 1'b1);
    nxt(); use_r4(16'h0000); bus.mem_reg_write = 1; bus.mem_rd = 4; bus.mem_data = 16'hBEEF; step();
`ifndef FWD_EN
    nxt(); use_r4(16'hBEEF); step();
`endif
    @(posedge clk); #2;
    check("t3_op1", bus.ex_op1, 16'hBEEF);
`ifdef FWD_EN
    check("t3_cnt", bus.bubble_cnt, 16'd1);
`else
    check("t3_cnt", bus.bubble_cnt, 16'd2);
`endif

    // EX and MEM both write r2; EX is younger and wins.
    nxt(); bus.id_valid = 1; bus.id_rd = 2; bus.id_reg_write = 1; step();
    nxt(); bus.id_valid = 1; bus.id_rs1 = 2; bus.id_rs1_used = 1; bus.ex_result = 16'h1111;
    bus.mem_reg_write = 1; bus.mem_rd = 2; bus.mem_data = 16'h2222; step();
`ifdef FWD_EN
    @(posedge clk); #2;
    check("t4_op1", bus.ex_op1, 16'h1111);
`else
    check("t4_stall", bus.id_stall, 1'b1);
`endif

    // Downstream stall holds a valid load; flush during the stall bubbles.
    nxt(); bus.id_valid = 1; bus.id_rd = 6; bus.id_reg_write = 1; bus.id_mem_read = 1;
    bus.id_rdata1 = 16'h1234; bus.id_use_imm = 1; bus.id_imm = 16'h0010; step();
    repeat (3) begin
      nxt(); bus.stall_in = 1; bus.id_valid = 1; bus.id_rdata1 = 16'($urandom); step();
    end
    @(posedge clk); #2;
    check("t5_hold_op1", bus.ex_op1, 16'h1234);
    check("t5_hold_op2", bus.ex_op2, 16'h0010);
    nxt(); bus.stall_in = 1; bus.flush = 1; step();
    @(posedge clk); #2;
    check("t5_flush_valid", bus.ex_valid, 1'b0);

    repeat (200) rand_cycle();

    // Counter saturation.
    do_reset();
`ifndef FWD_EN
    repeat (65539) begin
      nxt(); bus.id_valid = 1; bus.id_rs1 = 5; bus.id_rs1_used = 1;
      bus.mem_reg_write = 1; bus.mem_rd = 5; step();
    end
    @(posedge clk); #2;
    check("t6_saturate", bus.bubble_cnt, 16'hFFFF);
`else
    repeat (3) begin
      nxt(); bus.id_valid = 1; bus.id_rd = 5; bus.id_reg_write = 1; bus.id_mem_read = 1; step();
      nxt(); bus.id_valid = 1; bus.id_rs2 = 5; bus.id_rs2_used = 1; step();
    end
    @(posedge clk); #2;
    check("t6_count", bus.bubble_cnt, 16'd3);
`endif

    @(posedge clk); #2;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
